i2c_cmd_sequencer: RTL and testbench

//  Upstream command front-end for i2c_controller. Buffers byte-level I2C commands
//  (7-bit addr, rw, wdata) in a small FIFO and issues them to the controller one at a time.

---
 rtl/i2c_cmd_sequencer_pkg.sv | 29 ++
 rtl/i2c_cmd_fifo.sv | 71 +++++++
 rtl/i2c_cmd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared definitions for the I2C command sequencer.
//   - state_t : 3-bit FSM state encoding used by the top level.
//   - CMD_W   : width of one queued command word.
//   - cmd_t   : command word layout {rw[15], addr[14:8], wdata[7:0]}.
//   - pack_cmd: builds a command word from its fields.
package i2c_cmd_sequencer_pkg;

    localparam int CMD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    function automatic logic [CMD_W-1:0] pack_cmd(input logic rw, input logic [6:0] addr,
                                                  input logic [7:0] wdata);
        return {rw, addr, wdata};
    endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous FIFO holding queued I2C commands.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   push, din    : write request and data (ignored while full)
//   pop          : read request (ignored while empty)
//   dout         : current head entry, valid whenever empty is low
//   full, empty  : occupancy flags derived from the registered count
//   count        : number of stored entries, log2(DEPTH)+1 bits
module i2c_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is read combinationally so the sequencer can pop and latch the
    // command in the same cycle.
    assign dout  = mem[rd_ptr_reg];
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for an I2C byte controller. Commands are queued in a
// FIFO and issued one at a time: an enable pulse of ENABLE_HOLD cycles, then
// the controller's ready line is followed low (started) and high (done).
// Exactly one response is produced per command, in order; a wait state that
// lasts TIMEOUT cycles ends the command with rsp_err set.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : command handshake (ready = FIFO not full)
//   cmd_addr/cmd_rw/cmd_wdata        : command fields (rw=1 read)
//   rsp_valid/rsp_rdata/rsp_err      : one-cycle response strobe and payload
//   busy                             : FSM active or commands queued
//   ctl_addr/ctl_wdata/ctl_rw        : command presented to the controller
//   ctl_enable                       : start pulse to the controller
//   ctl_ready/ctl_data_out           : controller status and read data
module i2c_cmd_sequencer
    import i2c_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ENABLE_HOLD = 4,
    parameter int TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic [6:0] ctl_addr,
    output logic [7:0] ctl_wdata,
    output logic       ctl_rw,
    output logic       ctl_enable,
    input  logic       ctl_ready,
    input  logic [7:0] ctl_data_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = (ENABLE_HOLD > 1) ? $clog2(ENABLE_HOLD) : 1;
    localparam int TW = $clog2(TIMEOUT);

    state_t           state_reg;
    state_t           state_next;
    logic [EW-1:0]    en_cnt_reg;
    logic [TW-1:0]    to_cnt_reg;
    cmd_t             cur_reg;
    logic [7:0]       rdata_reg;
    logic             err_reg;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [CMD_W-1:0] fifo_dout;
    cmd_t             head;
    logic             enable_done;
    logic             timed_out;
    logic             in_wait;

    i2c_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .din   (pack_cmd(cmd_rw, cmd_addr, cmd_wdata)),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head        = cmd_t'(fifo_dout);
    assign enable_done = (en_cnt_reg == EW'(ENABLE_HOLD - 1));
    assign timed_out   = (to_cnt_reg == TW'(TIMEOUT - 1));
    assign in_wait     = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. The pop is part of the IDLE->ISSUE decision.
    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && ctl_ready) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (enable_done) begin
                    state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // Controller starting wins over a coincident timeout.
                if (!ctl_ready) begin
                    state_next = ST_WAIT_DONE;
                end else if (timed_out) begin
                    state_next = ST_RESP;
                end
            end
            ST_WAIT_DONE: begin
                if (ctl_ready || timed_out) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Counters, latched command and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_cnt_reg <= '0;
            to_cnt_reg <= '0;
            cur_reg    <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            en_cnt_reg <= (state_reg == ST_ISSUE && state_next == ST_ISSUE)
                          ? en_cnt_reg + 1'b1 : '0;
            // Any state change clears the timeout count, so it restarts on
            // entry to both WAIT_BUSY and WAIT_DONE.
            to_cnt_reg <= (in_wait && state_next == state_reg)
                          ? to_cnt_reg + 1'b1 : '0;
            if (fifo_pop) begin
                cur_reg <= head;
            end
            if (state_next == ST_RESP) begin
                if (state_reg == ST_WAIT_DONE && ctl_ready) begin
                    err_reg   <= 1'b0;
                    rdata_reg <= cur_reg.rw ? ctl_data_out : 8'h00;
                end else begin
                    err_reg   <= 1'b1;
                    rdata_reg <= 8'h00;
                end
            end
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        ctl_enable = (state_reg == ST_ISSUE);
        rsp_valid  = (state_reg == ST_RESP);
        rsp_err    = rsp_valid && err_reg;
        rsp_rdata  = rsp_valid ? rdata_reg : 8'h00;
        busy       = (state_reg != ST_IDLE) || (fifo_count != '0);
        cmd_ready  = !fifo_full;
        ctl_addr   = cur_reg.addr;
        ctl_wdata  = cur_reg.wdata;
        ctl_rw     = cur_reg.rw;
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
module tb_i2c_cmd_sequencer;

    localparam int TIMEOUT = 4096;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
        int         en_fall;
        int         rdy_fall;
        int         rdy_rise;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic [6:0] ctl_addr;
    logic [7:0] ctl_wdata;
    logic       ctl_rw;
    logic       ctl_enable;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    i2c_cmd_sequencer #(
        .DEPTH       (4),
        .ENABLE_HOLD (4),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_rw       (cmd_rw),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .ctl_addr     (ctl_addr),
        .ctl_wdata    (ctl_wdata),
        .ctl_rw       (ctl_rw),
        .ctl_enable   (ctl_enable),
        .ctl_ready    (m_ready),
        .ctl_data_out (m_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural controller: ready drops 3 cycles after an enable rise, stays
    // low for m_n cycles (longer while m_hold), then returns with data_out =
    // {0,addr} ^ 0x6C. ign_req > ign_done makes it ignore the next enable.
    logic       m_ready = 1'b1;
    logic [7:0] m_data = 8'h00;
    logic       m_hold = 1'b0;
    logic       en_d = 1'b0;
    int         m_n = 40;
    int         m_phase = 0;
    int         m_cnt = 0;
    int         ign_req = 0;
    int         ign_done = 0;

    always @(posedge clk) begin
        en_d <= ctl_enable;
        case (m_phase)
            0: begin
                if (ctl_enable && !en_d) begin
                    if (ign_done < ign_req) begin
                        ign_done <= ign_done + 1;
                    end else begin
                        m_phase <= 1;
                        m_cnt   <= 1;
                    end
                end
            end
            1: begin
                if (m_cnt == 3) begin
                    m_ready <= 1'b0;
                    m_phase <= 2;
                    m_cnt   <= 1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
            default: begin
                if (m_cnt >= m_n && !m_hold) begin
                    m_ready <= 1'b1;
                    m_data  <= {1'b0, ctl_addr} ^ 8'h6C;
                    m_phase <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        endcase
    end

    // Monitor on the falling edge: edge timestamps and the response log.
    rsp_t rsp_q[$];
    int   en_rise_cnt = 0;
    int   en_fall_cyc = 0;
    int   rdy_fall_cyc = 0;
    int   rdy_rise_cyc = 0;
    logic en_prev = 1'b0;
    logic rdy_prev = 1'b1;

    always @(negedge clk) begin : mon
        rsp_t r;
        if (ctl_enable && !en_prev) en_rise_cnt <= en_rise_cnt + 1;
        if (!ctl_enable && en_prev) en_fall_cyc <= cyc;
        if (!m_ready && rdy_prev)   rdy_fall_cyc <= cyc;
        if (m_ready && !rdy_prev)   rdy_rise_cyc <= cyc;
        en_prev  <= ctl_enable;
        rdy_prev <= m_ready;
        if (rsp_valid) begin
            r.rdata    = rsp_rdata;
            r.err      = rsp_err;
            r.cyc      = cyc;
            r.en_fall  = en_fall_cyc;
            r.rdy_fall = rdy_fall_cyc;
            r.rdy_rise = rdy_rise_cyc;
            rsp_q.push_back(r);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one command and hold it until accepted (bounded).
    task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] d);
        int   k;
        logic acc;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = d;
        k = 0;
        do begin
            acc = cmd_ready;
            step(1);
            k++;
        end while (!acc && k < 200);
        cmd_valid = 1'b0;
        if (!acc) check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_rsps(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(rsp_q.size() >= n), 32'd1);
    endtask

    task automatic get_rsp(output rsp_t r);
        if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
        end else begin
            r.rdata = 'x; r.err = 'x; r.cyc = -1;
            r.en_fall = 0; r.rdy_fall = 0; r.rdy_rise = 0;
        end
    endtask

    initial begin : stim
        rsp_t       r;
        int         lat;
        int         hold;
        int         c0;
        int         n_rsp;
        int         n_en;
        logic       ok;
        logic [6:0] t3_addr [5];
        logic       t3_rw   [5];
        logic [7:0] t3_exp  [5];

        // Reset state.
        step(3);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_enable", 32'(ctl_enable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ctl_addr", 32'(ctl_addr), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        rst = 1'b0;
        step(2);

        // 1) Write 0x55/0xA5, controller busy 40 cycles.
        m_n = 40;
        lat = 1;
        push(7'h55, 1'b0, 8'hA5);
        while (!ctl_enable && lat < 20) begin
            step(1);
            lat++;
        end
        check("t1_enable_latency", 32'(lat), 32'd2);
        hold = 0;
        ok = 1'b1;
        while (ctl_enable && hold < 20) begin
            if (ctl_addr !== 7'h55 || ctl_wdata !== 8'hA5 || ctl_rw !== 1'b0) ok = 1'b0;
            hold++;
            step(1);
        end
        check("t1_enable_cycles", 32'(hold), 32'd4);
        check("t1_ctl_fields", 32'(ok), 32'd1);
        wait_rsps(1, 200, "t1_rsp_arrived");
        get_rsp(r);
        check("t1_rsp_err", 32'(r.err), 32'd0);
        check("t1_rsp_rdata", 32'(r.rdata), 32'h00);
        check("t1_done_to_rsp", 32'(r.cyc - r.rdy_rise), 32'd1);
        check("t1_addr_held", 32'(ctl_addr), 32'h55);
        step(2);

        // 2) Read 0x50 -> 0x3C.
        push(7'h50, 1'b1, 8'h00);
        wait_rsps(1, 200, "t2_rsp_arrived");
        get_rsp(r);
        check("t2_rsp_err", 32'(r.err), 32'd0);
        check("t2_rsp_rdata", 32'(r.rdata), 32'h3C);
        step(2);

        // 3) Five back-to-back pushes with the controller stalled.
        t3_addr = '{7'h10, 7'h21, 7'h32, 7'h43, 7'h7F};
        t3_rw   = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        t3_exp  = '{8'h7C, 8'h00, 8'h5E, 8'h00, 8'h13};
        m_n = 10;
        m_hold = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 5; i++) push(t3_addr[i], t3_rw[i], 8'h11 * 8'(i + 1));
        check("t3_push_cycles", 32'(cyc - c0), 32'd5);
        check("t3_full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h66;
        step(3);
        check("t3_still_full", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        m_hold = 1'b0;
        wait_rsps(5, 1000, "t3_rsp_arrived");
        step(20);
        check("t3_rsp_count", 32'(rsp_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            get_rsp(r);
            check($sformatf("t3_rdata_%0d", i), 32'(r.rdata), 32'(t3_exp[i]));
            check($sformatf("t3_err_%0d", i), 32'(r.err), 32'd0);
        end

        // 4) Controller ignores the first enable; the next command runs normally.
        ign_req = ign_req + 1;
        push(7'h11, 1'b0, 8'h5A);
        push(7'h22, 1'b1, 8'h00);
        wait_rsps(2, TIMEOUT + 400, "t4_rsp_arrived");
        get_rsp(r);
        check("t4a_err", 32'(r.err), 32'd1);
        check("t4a_rdata", 32'(r.rdata), 32'h00);
        check("t4a_timeout_cycles", 32'(r.cyc - r.en_fall), 32'(TIMEOUT));
        get_rsp(r);
        check("t4b_err", 32'(r.err), 32'd0);
        check("t4b_rdata", 32'(r.rdata), 32'h4E);
        step(2);

        // 5) Controller never finishes. The FSM enters WAIT_DONE one cycle
        //    after ready falls, so the response lands TIMEOUT+1 after the fall.
        m_hold = 1'b1;
        push(7'h33, 1'b1, 8'h00);
        wait_rsps(1, TIMEOUT + 400, "t5_rsp_arrived");
        get_rsp(r);
        check("t5_err", 32'(r.err), 32'd1);
        check("t5_rdata", 32'(r.rdata), 32'h00);
        check("t5_timeout_cycles", 32'(r.cyc - r.rdy_fall), 32'(TIMEOUT + 1));
        m_hold = 1'b0;
        step(5);
        check("t5_idle", 32'(busy), 32'd0);

        // 6) Reset during WAIT_DONE with two commands queued.
        m_hold = 1'b1;
        push(7'h01, 1'b0, 8'h01);
        push(7'h02, 1'b1, 8'h00);
        push(7'h03, 1'b1, 8'h00);
        c0 = 0;
        while (m_ready && c0 < 50) begin
            step(1);
            c0++;
        end
        step(6);
        check("t6_pre_busy", 32'(busy), 32'd1);
        n_rsp = rsp_q.size();
        n_en  = en_rise_cnt;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_enable", 32'(ctl_enable), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        m_hold = 1'b0;
        step(100);
        check("t6_no_rsp", 32'(rsp_q.size()), 32'(n_rsp));
        check("t6_no_issue", 32'(en_rise_cnt), 32'(n_en));
        check("t6_busy_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
